mod_counter: RTL and testbench

Parametrised up/down counter, the next generation of the lab-work free-running 16-bit hex counter. It adds:
- configurable width and terminal value;
- count direction, enable and prescaler;
- synchronous clear and parallel load;
- wrap or saturate mode, with terminal-count and sticky overflow flags.

It sits wherever the design needs a timebase, event counter or display-digit source. It drives the 7-segment and LED paths directly from its `counter` output.

---
 rtl/mod_counter.sv | 159 +++++++++++++++
 tb/tb_mod_counter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
//   Parametrised up/down counter with prescaler, synchronous clear and
//   parallel load, wrap or saturate behaviour at the limits, a one-cycle
//   terminal-count pulse and a sticky overflow flag.
//
// Parameters
//   WIDTH    : counter width in bits (2..32)
//   MAX      : terminal value, count range is 0..MAX (must fit in WIDTH bits)
//   WRAP     : 1 = wrap at the limits, 0 = saturate at the limits
//   PRESCALE : enabled cycles per count step (1..65535)
//
// Ports
//   clk        in  : rising-edge clock
//   reset      in  : asynchronous active-high reset
//   enable     in  : count enable, gates the prescaler
//   up         in  : direction, 1 = increment, 0 = decrement
//   clear      in  : synchronous clear (highest synchronous priority)
//   load       in  : synchronous parallel load
//   load_value in  : value captured on load, clamped to MAX
//   counter    out : current count (registered)
//   tc         out : one-cycle pulse on every limit hit (registered)
//   overflow   out : sticky flag, set on any limit hit (registered)
// -----------------------------------------------------------------------------
module mod_counter #(
  parameter int          WIDTH    = 16,
  parameter int unsigned MAX      = 32'((64'd1 << WIDTH) - 64'd1),
  parameter int          WRAP     = 1,
  parameter int          PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] counter,
  output logic             tc,
  output logic             overflow
);

  // Prescaler width: ceil(log2(PRESCALE)), never below one bit.
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0]  PS_ONE  = PS_W'(1'b1);
  localparam logic [PS_W-1:0]  PS_ZERO = PS_W'(1'b0);
  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ZERO_V  = WIDTH'(1'b0);
  localparam logic [WIDTH-1:0] ONE_V   = WIDTH'(1'b1);

  // When MAX covers the whole WIDTH range no load value can exceed it, so the
  // clamp comparator is left out instead of becoming a constant-false compare.
  localparam bit FULL_RANGE = (64'(MAX) == ((64'd1 << WIDTH) - 64'd1));

  logic [WIDTH-1:0] counter_r;
  logic             tc_r;
  logic             overflow_r;
  logic [PS_W-1:0]  ps_r;

  logic [WIDTH-1:0] cnt_nxt_s;
  logic             tc_nxt_s;
  logic             ov_nxt_s;
  logic [PS_W-1:0]  ps_nxt_s;

  logic [WIDTH-1:0] load_clamped_s;
  logic             step_due_s;
  logic             at_limit_s;
  logic [WIDTH-1:0] limit_target_s;
  logic [WIDTH-1:0] normal_target_s;

  generate
    if (FULL_RANGE) begin : g_no_clamp
      assign load_clamped_s = load_value;
    end else begin : g_clamp
      assign load_clamped_s = (load_value > MAX_V) ? MAX_V : load_value;
    end
  endgenerate

  // Step qualification and the two candidate step results.
  always_comb begin
    step_due_s      = (ps_r == PS_LAST);
    at_limit_s      = 1'b0;
    limit_target_s  = counter_r;
    normal_target_s = counter_r;
    if (up) begin
      at_limit_s      = (counter_r == MAX_V);
      normal_target_s = counter_r + ONE_V;
      if (WRAP != 0) begin
        limit_target_s = ZERO_V;
      end else begin
        limit_target_s = counter_r;
      end
    end else begin
      at_limit_s      = (counter_r == ZERO_V);
      normal_target_s = counter_r - ONE_V;
      if (WRAP != 0) begin
        limit_target_s = MAX_V;
      end else begin
        limit_target_s = counter_r;
      end
    end
  end

  // Next-state selection: clear > load > count step; tc defaults low so it
  // can only ever last one cycle.
  always_comb begin
    cnt_nxt_s = counter_r;
    ps_nxt_s  = ps_r;
    tc_nxt_s  = 1'b0;
    ov_nxt_s  = overflow_r;
    if (clear) begin
      cnt_nxt_s = ZERO_V;
      ps_nxt_s  = PS_ZERO;
      ov_nxt_s  = 1'b0;
    end else if (load) begin
      // Load restarts the prescaler and swallows any step due on this edge.
      cnt_nxt_s = load_clamped_s;
      ps_nxt_s  = PS_ZERO;
    end else if (enable) begin
      if (step_due_s) begin
        ps_nxt_s = PS_ZERO;
        if (at_limit_s) begin
          // Saturate mode still reports every attempted step at a limit.
          cnt_nxt_s = limit_target_s;
          tc_nxt_s  = 1'b1;
          ov_nxt_s  = 1'b1;
        end else begin
          cnt_nxt_s = normal_target_s;
        end
      end else begin
        ps_nxt_s = ps_r + PS_ONE;
      end
    end else begin
      ps_nxt_s = ps_r;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter_r  <= ZERO_V;
      tc_r       <= 1'b0;
      overflow_r <= 1'b0;
      ps_r       <= PS_ZERO;
    end else begin
      counter_r  <= cnt_nxt_s;
      tc_r       <= tc_nxt_s;
      overflow_r <= ov_nxt_s;
      ps_r       <= ps_nxt_s;
    end
  end

  assign counter  = counter_r;
  assign tc       = tc_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_mod_counter.sv
// -----------------------------------------------------------------------------
// tb_mod_counter
//   Three mod_counter instances sharing the control inputs:
//     a : WIDTH=16, defaults (MAX=0xFFFF, wrap, PRESCALE=1)
//     b : WIDTH=4,  MAX=9,   wrap,     PRESCALE=3
//     c : WIDTH=8,  MAX=100, saturate, PRESCALE=3
//   Every edge is checked against an arithmetic reference model; directed
//   table rows and hand-written sequences add fixed expected values.
// -----------------------------------------------------------------------------
module tb_mod_counter;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        up;
  logic        clear;
  logic        load;
  logic [15:0] lv_a;
  logic [3:0]  lv_b;
  logic [7:0]  lv_c;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;
  logic [7:0]  cnt_c;
  logic        tc_a, tc_b, tc_c;
  logic        ov_a, ov_b, ov_c;

  int total;
  int bad;

  localparam int P_MAX[3]  = '{65535, 9, 100};
  localparam int P_PRE[3]  = '{1, 3, 3};
  localparam int P_WRAP[3] = '{1, 1, 0};

  int m_cnt[3];
  int m_ps[3];
  int m_tc[3];
  int m_ov[3];

  mod_counter #(.WIDTH(16)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .clear(clear),
    .load(load), .load_value(lv_a), .counter(cnt_a), .tc(tc_a), .overflow(ov_a));

  mod_counter #(.WIDTH(4), .MAX(9), .WRAP(1), .PRESCALE(3)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .clear(clear),
    .load(load), .load_value(lv_b), .counter(cnt_b), .tc(tc_b), .overflow(ov_b));

  mod_counter #(.WIDTH(8), .MAX(100), .WRAP(0), .PRESCALE(3)) dut_c (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .clear(clear),
    .load(load), .load_value(lv_c), .counter(cnt_c), .tc(tc_c), .overflow(ov_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int act_cnt(input int i);
    case (i)
      0: return int'(cnt_a);
      1: return int'(cnt_b);
      default: return int'(cnt_c);
    endcase
  endfunction

  function automatic int act_tc(input int i);
    case (i)
      0: return int'(tc_a);
      1: return int'(tc_b);
      default: return int'(tc_c);
    endcase
  endfunction

  function automatic int act_ov(input int i);
    case (i)
      0: return int'(ov_a);
      1: return int'(ov_b);
      default: return int'(ov_c);
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_ps[i] = 0; m_tc[i] = 0; m_ov[i] = 0;
    end
  endtask

  // Reference behaviour of one clock edge, written with modulo arithmetic.
  task automatic model_edge();
    int lv[3];
    lv[0] = int'(lv_a);
    lv[1] = int'(lv_b);
    lv[2] = int'(lv_c);
    for (int i = 0; i < 3; i++) begin
      m_tc[i] = 0;
      if (clear) begin
        m_cnt[i] = 0; m_ps[i] = 0; m_ov[i] = 0;
      end else if (load) begin
        m_cnt[i] = (lv[i] > P_MAX[i]) ? P_MAX[i] : lv[i];
        m_ps[i]  = 0;
      end else if (enable) begin
        m_ps[i] = (m_ps[i] + 1) % P_PRE[i];
        if (m_ps[i] == 0) begin
          if ((up && m_cnt[i] == P_MAX[i]) || (!up && m_cnt[i] == 0)) begin
            m_tc[i] = 1;
            m_ov[i] = 1;
          end
          if (P_WRAP[i] != 0)
            m_cnt[i] = (m_cnt[i] + (up ? 1 : P_MAX[i])) % (P_MAX[i] + 1);
          else if (up)
            m_cnt[i] = (m_cnt[i] < P_MAX[i]) ? m_cnt[i] + 1 : P_MAX[i];
          else
            m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
        end
      end
    end
  endtask

  task automatic compare_model();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("model cnt[%0d]", i), act_cnt(i), m_cnt[i]);
      check($sformatf("model tc[%0d]", i),  act_tc(i),  m_tc[i]);
      check($sformatf("model ov[%0d]", i),  act_ov(i),  m_ov[i]);
    end
  endtask

  // One rising edge, then model update and comparison 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
    compare_model();
  endtask

  // Assert reset between edges (called just after a tick), check the
  // immediate effect, hold it over one edge and release on a falling edge.
  task automatic async_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("async cnt_a", int'(cnt_a), 0);
    check("async tc_a",  int'(tc_a),  0);
    check("async ov_a",  int'(ov_a),  0);
    check("async ov_c",  int'(ov_c),  0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic       en;
    logic       up;
    logic       clr;
    logic       ld;
    logic [7:0] lv;
    int         cnt;
    int         tc;
    int         ov;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic en, input logic u, input logic clr, input logic ld,
                              input logic [7:0] lv, input int cnt, input int t, input int ov);
    vec_t v;
    v.en = en; v.up = u; v.clr = clr; v.ld = ld; v.lv = lv;
    v.cnt = cnt; v.tc = t; v.ov = ov;
    return v;
  endfunction

  int n_tc;

  initial begin
    total  = 0;
    bad    = 0;
    reset  = 1'b1;
    enable = 1'b0;
    up     = 1'b1;
    clear  = 1'b0;
    load   = 1'b0;
    lv_a   = 16'h0000;
    lv_b   = 4'h0;
    lv_c   = 8'h00;
    model_reset();

    // Reset state.
    #4;
    check("reset cnt_a", int'(cnt_a), 0);
    check("reset cnt_b", int'(cnt_b), 0);
    check("reset cnt_c", int'(cnt_c), 0);
    check("reset tc_a",  int'(tc_a),  0);
    check("reset ov_a",  int'(ov_a),  0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Full-range count on a: 0xFFFF then wrap to 0 with a single tc pulse.
    enable = 1'b1;
    up     = 1'b1;
    n_tc   = 0;
    for (int k = 1; k <= 65536; k++) begin
      tick();
      if (tc_a) n_tc++;
      if (k == 65535) begin
        check("full cnt_a at FFFF", int'(cnt_a), 16'hFFFF);
        check("full tc_a before wrap", int'(tc_a), 0);
      end
    end
    check("full cnt_a wrapped", int'(cnt_a), 0);
    check("full tc_a at wrap", int'(tc_a), 1);
    check("full ov_a set", int'(ov_a), 1);
    check("full tc_a pulses", n_tc, 1);
    tick();
    check("full tc_a drops", int'(tc_a), 0);
    check("full ov_a sticky", int'(ov_a), 1);

    // Load keeps overflow; count to 0x1234 then reset between edges.
    enable = 1'b0;
    load   = 1'b1;
    lv_a   = 16'h1230;
    lv_b   = 4'h2;
    lv_c   = 8'h05;
    tick();
    check("load keeps ov_a", int'(ov_a), 1);
    load   = 1'b0;
    enable = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    check("cnt_a at 1234", int'(cnt_a), 16'h1234);
    async_reset();

    // After release b (PRESCALE=3, MAX=9) needs 3 edges per step; 30 steps.
    n_tc = 0;
    for (int k = 1; k <= 90; k++) begin
      tick();
      if (tc_b) n_tc++;
      if (k == 2) check("b no step after 2", int'(cnt_b), 0);
      if (k == 3) check("b first step", int'(cnt_b), 1);
      if (k == 30) check("b wrap value", int'(cnt_b), 0);
    end
    check("b after 90", int'(cnt_b), 0);
    check("b tc at 90", int'(tc_b), 1);
    check("b tc pulses", n_tc, 3);
    check("a after 90", int'(cnt_a), 90);
    async_reset();

    // Directed table for c (MAX=100, saturate, PRESCALE=3).
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd2,   2,   0, 0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   2,   0, 0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   2,   0, 0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   1,   0, 0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   1,   0, 0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   1,   0, 0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   0,   0, 0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   0,   0, 0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   0,   0, 0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   0,   1, 1));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   0,   0, 1));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   0,   0, 1));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   0,   1, 1));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   0,   0, 0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   0,   0, 0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   0,   0, 0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 8'd200, 100, 0, 0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   100, 0, 0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   100, 0, 0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   100, 1, 1));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   100, 0, 1));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   100, 0, 1));
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 8'd200, 0,   0, 0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   0,   0, 0));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 0,   0, 0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   0,   0, 0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   1,   0, 0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   1,   0, 0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   1,   0, 0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   0,   0, 0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   0,   0, 0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   0,   0, 0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   0,   1, 1));

    for (int r = 0; r < tbl.size(); r++) begin
      enable = tbl[r].en;
      up     = tbl[r].up;
      clear  = tbl[r].clr;
      load   = tbl[r].ld;
      lv_a   = {8'h00, tbl[r].lv};
      lv_b   = tbl[r].lv[3:0];
      lv_c   = tbl[r].lv;
      tick();
      check($sformatf("row%0d cnt_c", r), int'(cnt_c), tbl[r].cnt);
      check($sformatf("row%0d tc_c", r),  int'(tc_c),  tbl[r].tc);
      check($sformatf("row%0d ov_c", r),  int'(ov_c),  tbl[r].ov);
    end

    // Randomised traffic against the model, with occasional async resets.
    for (int k = 0; k < 3000; k++) begin
      enable = ($urandom_range(0, 3) != 0);
      up     = ($urandom_range(0, 99) < 55);
      clear  = ($urandom_range(0, 63) == 0);
      load   = ($urandom_range(0, 15) == 0);
      lv_a   = 16'($urandom);
      lv_b   = 4'($urandom_range(0, 15));
      lv_c   = 8'($urandom_range(0, 255));
      tick();
      if ($urandom_range(0, 499) == 0) async_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
